// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch flush and multicycle EX occupancy.
// Optional PIPE_HAZARD_PERF_CNT_EN adds stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MC_CYCLES = 34
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [4:0] RS1_D,
  input  logic [4:0] RS2_D,
  input  logic [4:0] RD_E,
  input  logic       MEMREAD_E,
  input  logic       PC_SRC_E,
  input  logic       MC_START_E,
  output logic       STALL_F,
  output logic       STALL_D,
  output logic       STALL_E,
  output logic       FLUSH_D,
  output logic       FLUSH_E,
  output logic       FLUSH_M,
  output logic       MC_DONE
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] STALL_CNT,
  output logic [31:0] FLUSH_CNT
`endif
);

  typedef enum logic {RUN = 1'b0, MCBUSY = 1'b1} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(MC_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       load_use;

  assign load_use = MEMREAD_E && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

  // Outputs are decoded from the current cycle so hazards act with no added latency;
  // CLR masks everything so the pipeline sees no stall/flush while reset is held.
  always_comb begin
    STALL_F = 1'b0;
    STALL_D = 1'b0;
    STALL_E = 1'b0;
    FLUSH_D = 1'b0;
    FLUSH_E = 1'b0;
    FLUSH_M = 1'b0;
    MC_DONE = 1'b0;
    if (!CLR) begin
      case (state)
        RUN: begin
          if (PC_SRC_E) begin
            FLUSH_D = 1'b1;
            FLUSH_E = 1'b1;
          end else if (MC_START_E) begin
            STALL_F = 1'b1;
            STALL_D = 1'b1;
            STALL_E = 1'b1;
            FLUSH_M = 1'b1;
          end else if (load_use) begin
            STALL_F = 1'b1;
            STALL_D = 1'b1;
            FLUSH_E = 1'b1;
          end
        end
        MCBUSY: begin
          if (cnt > 8'd1) begin
            STALL_F = 1'b1;
            STALL_D = 1'b1;
            STALL_E = 1'b1;
            FLUSH_M = 1'b1;
          end else begin
            MC_DONE = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The start cycle counts as the first EX cycle, hence the MC_CYCLES-1 load.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else begin
      case (state)
        RUN: begin
          if (!PC_SRC_E && MC_START_E) begin
            state <= MCBUSY;
            cnt   <= CNT_LOAD;
          end
        end
        MCBUSY: begin
          if (cnt > 8'd1) begin
            cnt <= cnt - 8'd1;
          end else begin
            state <= RUN;
            cnt   <= 8'd0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      STALL_CNT <= 32'd0;
      FLUSH_CNT <= 32'd0;
    end else begin
      if (STALL_F) STALL_CNT <= STALL_CNT + 32'd1;
      if (FLUSH_D) FLUSH_CNT <= FLUSH_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: three controllers (MC_CYCLES 4, 3, 34) share decode/EX inputs,
// each with its own multicycle start; expected outputs are queued per cycle.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] NONE   = 7'b000_000_0;
  localparam logic [6:0] LU     = 7'b110_010_0;
  localparam logic [6:0] BR     = 7'b000_110_0;
  localparam logic [6:0] STALL3 = 7'b111_001_0;
  localparam logic [6:0] DONE   = 7'b000_000_1;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [4:0] rs1, rs2, rd;
  logic       memread, pcsrc;
  logic [2:0] mcs;
  logic [2:0] sf, sd, se, fd, fe, fm, md;
  logic [2:0][6:0] act;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [2:0][31:0] scnt, fcnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         sel;
    logic [6:0] exp;
    string      name;
  } exp_t;
  exp_t q[$];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned MCV = (g == 0) ? 4 : (g == 1) ? 3 : 34;
    pipe_hazard_ctrl #(.MC_CYCLES(MCV)) u_dut (
      .CLK(CLK), .CLR(CLR),
      .RS1_D(rs1), .RS2_D(rs2), .RD_E(rd),
      .MEMREAD_E(memread), .PC_SRC_E(pcsrc), .MC_START_E(mcs[g]),
      .STALL_F(sf[g]), .STALL_D(sd[g]), .STALL_E(se[g]),
      .FLUSH_D(fd[g]), .FLUSH_E(fe[g]), .FLUSH_M(fm[g]),
      .MC_DONE(md[g])
`ifdef PIPE_HAZARD_PERF_CNT_EN
      , .STALL_CNT(scnt[g]), .FLUSH_CNT(fcnt[g])
`endif
    );
    assign act[g] = {sf[g], sd[g], se[g], fd[g], fe[g], fm[g], md[g]};
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // One cycle of stimulus: inputs are already set, queue the expectation, advance.
  task automatic cyc(input int sel, input logic [6:0] e, input string nm);
    exp_t x;
    x.sel = sel; x.exp = e; x.name = nm;
    q.push_back(x);
    @(posedge CLK); #1;
  endtask

  task automatic idle_in();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; memread = 1'b0; pcsrc = 1'b0; mcs = 3'b000;
  endtask

  // Monitor: outputs are combinational, so every cycle with a queued entry is compared mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        x = q.pop_front();
        check(x.name, 32'(act[x.sel]), 32'(x.exp));
      end
    end
  end

  initial begin
    idle_in();
    CLR = 1'b1;
    @(posedge CLK); #1;

    // Reset masks outputs even with every hazard input active
    memread = 1'b1; rd = 5'd5; rs2 = 5'd5; pcsrc = 1'b1; mcs = 3'b111;
    cyc(0, NONE, "reset_u4");
    cyc(1, NONE, "reset_u3");
`ifdef PIPE_HAZARD_PERF_CNT_EN
    check("reset_stall_cnt", scnt[0], 32'd0);
    check("reset_flush_cnt", fcnt[0], 32'd0);
`endif
    idle_in();
    CLR = 1'b0;
    cyc(0, NONE, "idle");

    // Load-use on RS2, then on RS1, each for exactly one cycle
    memread = 1'b1; rd = 5'd5; rs2 = 5'd5;
    cyc(0, LU, "lu_rs2");
    idle_in();
    cyc(0, NONE, "lu_one_cycle");
    memread = 1'b1; rd = 5'd7; rs1 = 5'd7;
    cyc(0, LU, "lu_rs1");
    idle_in();
    memread = 1'b1; rd = 5'd0; rs1 = 5'd0;
    cyc(0, NONE, "lu_x0");
    rd = 5'd3; rs1 = 5'd4; rs2 = 5'd6;
    cyc(0, NONE, "lu_nomatch");
    rd = 5'd5; rs2 = 5'd5; memread = 1'b0;
    cyc(0, NONE, "match_no_load");

    // Branch wins over a simultaneous load-use
    memread = 1'b1; rd = 5'd5; rs2 = 5'd5; pcsrc = 1'b1;
    cyc(0, BR, "branch_lu");
    pcsrc = 1'b0;

    // Multicycle (4) with a load-use present: multicycle rule wins; busy ignores branch
    mcs = 3'b001;
    cyc(0, STALL3, "mc4_start");
    pcsrc = 1'b1;
    cyc(0, STALL3, "mc4_busy_br");
    pcsrc = 1'b0;
    cyc(0, STALL3, "mc4_busy");
    cyc(0, DONE, "mc4_done");
    idle_in();
    cyc(0, NONE, "mc4_run");

    // Back-to-back multicycle ops (3): done pulses 3 cycles apart, no gap
    mcs = 3'b010;
    cyc(1, STALL3, "mc3a_start");
    cyc(1, STALL3, "mc3a_busy");
    cyc(1, DONE, "mc3a_done");
    cyc(1, STALL3, "mc3b_start");
    cyc(1, STALL3, "mc3b_busy");
    cyc(1, DONE, "mc3b_done");
    mcs = 3'b000;
    cyc(1, NONE, "mc3_run");

    // Multicycle (34): run until CNT=10, then async CLR mid-cycle
    mcs = 3'b100;
    cyc(2, STALL3, "mc34_start");
    for (int i = 0; i < 23; i++) cyc(2, STALL3, "mc34_busy");
    memread = 1'b1; rd = 5'd5; rs1 = 5'd5;
    CLR = 1'b1;
    cyc(2, NONE, "clr_async");
    CLR = 1'b0;
    idle_in();
    cyc(2, NONE, "clr_release");
    memread = 1'b1; rd = 5'd5; rs1 = 5'd5;
    cyc(2, LU, "post_clr_lu");
    idle_in();

    // Performance-counter scenario: one load-use, one branch, one 4-cycle op
    CLR = 1'b1;
    cyc(0, NONE, "perf_clr");
    CLR = 1'b0;
    memread = 1'b1; rd = 5'd9; rs1 = 5'd9;
    cyc(0, LU, "perf_lu");
    idle_in();
    pcsrc = 1'b1;
    cyc(0, BR, "perf_br");
    pcsrc = 1'b0;
    mcs = 3'b001;
    cyc(0, STALL3, "perf_mc_start");
    cyc(0, STALL3, "perf_mc_busy1");
    cyc(0, STALL3, "perf_mc_busy2");
    cyc(0, DONE, "perf_mc_done");
    mcs = 3'b000;
    cyc(0, NONE, "perf_run");
`ifdef PIPE_HAZARD_PERF_CNT_EN
    check("stall_cnt", scnt[0], 32'd4);
    check("flush_cnt", fcnt[0], 32'd1);
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
